cpu_controller: RTL and testbench

- Instruction sequencer for the 8-bit RISC CPU: an internal 3-bit phase counter runs 8 phases per instruction.
- Decodes phase, current opcode and accumulator-zero flag into the load/select/read/write strobes for the register file (IR, AC), PC counter, address mux, memory and ALU data driver.
- Sits between the instruction register output and every datapath `load` input; the datapath registers sample these strobes on the next rising `clk`.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/cpu_controller_phase_counter.sv | 33 +++
 rtl/cpu_controller.sv | 115 +++++++++++
 tb/tb_cpu_controller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared ISA definitions for the 8-bit RISC CPU: opcodes, instruction
// phases and the ALU-operation membership test.
package cpu_pkg;

  localparam logic [2:0] HLT = 3'd0;
  localparam logic [2:0] SKZ = 3'd1;
  localparam logic [2:0] ADD = 3'd2;
  localparam logic [2:0] AND = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] LDA = 3'd5;
  localparam logic [2:0] STO = 3'd6;
  localparam logic [2:0] JMP = 3'd7;

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  // Opcodes whose result is written into the accumulator from memory data.
  function automatic logic is_aluop(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/cpu_controller_phase_counter.sv
// 3-bit instruction phase counter: synchronous active-low clear, advances
// when enabled and not frozen, wraps 7 -> 0.
module phase_counter (
  input  logic       clk,
  input  logic       rst_,
  input  logic       en_i,
  input  logic       freeze_i,
  output logic [2:0] count_o
);

  logic [2:0] count_q;
  logic [2:0] count_d;

  // Next count: hold unless enabled and not frozen.
  always_comb begin
    count_d = count_q;
    if (en_i && !freeze_i) begin
      count_d = count_q + 3'd1;
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      count_q <= 3'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/cpu_controller.sv
// Instruction sequencer: steps through 8 phases per instruction and decodes
// phase/opcode/zero into datapath strobes. HLT latches a sticky halt that
// only reset clears.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_,
  input  logic       enable,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       ld_ac,
  output logic       ld_pc,
  output logic       inc_pc,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  logic       halted_q;
  logic       halted_d;
  logic       halt_now;
  logic       freeze;
  logic [2:0] phase_w;
  phase_e     phase_s;

  assign phase_s  = phase_e'(phase_w);
  // HLT decoded in OP_ADDR stops the counter at the same edge it latches.
  assign halt_now = (phase_s == OP_ADDR) && (opcode == HLT);
  assign freeze   = halted_q || halt_now;

  phase_counter u_phase_counter (
    .clk      (clk),
    .rst_     (rst_),
    .en_i     (enable),
    .freeze_i (freeze),
    .count_o  (phase_w)
  );

  // Halt latch next state: set on an enabled HLT in OP_ADDR, sticky after.
  always_comb begin
    halted_d = halted_q || (halt_now && enable);
  end

  // Halt latch register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  // Strobe decode; while halted everything but halt is forced low.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      case (phase_s)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = (opcode != HLT);
          halt   = (opcode == HLT);
        end
        OP_FETCH: begin
          rd = is_aluop(opcode);
        end
        ALU_OP: begin
          rd     = is_aluop(opcode);
          inc_pc = (opcode == SKZ) && zero;
          ld_pc  = (opcode == JMP);
          data_e = (opcode == STO);
        end
        STORE: begin
          rd     = is_aluop(opcode);
          ld_ac  = is_aluop(opcode);
          ld_pc  = (opcode == JMP);
          inc_pc = (opcode == JMP);
          wr     = (opcode == STO);
          data_e = (opcode == STO);
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

  assign phase = phase_w;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller. Strobes are viewed as one 9-bit word
// {sel, rd, ld_ir, ld_ac, ld_pc, inc_pc, wr, data_e, halt}.
module tb_cpu_controller;

  logic       clk;
  logic       rst_;
  logic       enable;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, ld_ac, ld_pc, inc_pc, wr, data_e, halt;
  logic [2:0] phase;
  logic [8:0] outs;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_controller dut (
    .clk    (clk),
    .rst_   (rst_),
    .enable (enable),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .ld_ac  (ld_ac),
    .ld_pc  (ld_pc),
    .inc_pc (inc_pc),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt),
    .phase  (phase)
  );

  assign outs = {sel, rd, ld_ir, ld_ac, ld_pc, inc_pc, wr, data_e, halt};

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: inputs change #1 after the rising edge, sampling follows.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    tick();
    rst_ = 1'b1;
  endtask

  // Walks one full instruction with a fixed opcode for phases 4-7 and HLT
  // on the opcode bus in phases 0-3 (which must not matter there).
  task automatic run_instr(input string name, input logic [2:0] op, input logic z,
                           input logic [8:0] e4, input logic [8:0] e5,
                           input logic [8:0] e6, input logic [8:0] e7);
    logic [8:0] exp_q [8];
    exp_q[0] = 9'b100000000;
    exp_q[1] = 9'b110000000;
    exp_q[2] = 9'b111000000;
    exp_q[3] = 9'b111000000;
    exp_q[4] = e4;
    exp_q[5] = e5;
    exp_q[6] = e6;
    exp_q[7] = e7;
    enable = 1'b1;
    zero   = z;
    opcode = 3'd0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      opcode = (i < 4) ? 3'd0 : op;
      #1;
      n_checks++;
      if (outs !== exp_q[i] || phase !== 3'(i)) begin
        n_fail++;
        $display("FAIL %s phase%0d: got outs=%b phase=%0d, want outs=%b phase=%0d",
                 name, i, outs, phase, exp_q[i], i);
      end
      tick();
    end
    n_checks++;
    if (phase !== 3'd0) begin
      n_fail++;
      $display("FAIL %s wrap: got phase=%0d, want 0", name, phase);
    end
  endtask

  task automatic test_reset();
    enable = 1'b1;
    opcode = 3'd2;
    zero   = 1'b0;
    do_reset();
    n_checks++;
    if (outs !== 9'b100000000 || phase !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got outs=%b phase=%0d, want 100000000 phase=0", outs, phase);
    end
  endtask

  task automatic test_reset_mid();
    enable = 1'b1;
    opcode = 3'd2;
    do_reset();
    repeat (5) tick();
    n_checks++;
    if (phase !== 3'd5 || outs !== 9'b010000000) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got outs=%b phase=%0d, want 010000000 phase=5", outs, phase);
    end
    @(negedge clk);
    rst_ = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (phase !== 3'd0 || outs !== 9'b100000000) begin
      n_fail++;
      $display("FAIL reset_mid: got outs=%b phase=%0d, want 100000000 phase=0", outs, phase);
    end
    rst_ = 1'b1;
    tick();
    n_checks++;
    if (phase !== 3'd1) begin
      n_fail++;
      $display("FAIL reset_resume: got phase=%0d, want 1", phase);
    end
  endtask

  task automatic test_lda();
    run_instr("lda", 3'd5, 1'b0, 9'b000001000, 9'b010000000, 9'b010000000, 9'b010100000);
  endtask

  task automatic test_add();
    run_instr("add", 3'd2, 1'b1, 9'b000001000, 9'b010000000, 9'b010000000, 9'b010100000);
  endtask

  task automatic test_sto();
    run_instr("sto", 3'd6, 1'b0, 9'b000001000, 9'b000000000, 9'b000000010, 9'b000000110);
  endtask

  task automatic test_skz();
    run_instr("skz_z1", 3'd1, 1'b1, 9'b000001000, 9'b000000000, 9'b000001000, 9'b000000000);
    run_instr("skz_z0", 3'd1, 1'b0, 9'b000001000, 9'b000000000, 9'b000000000, 9'b000000000);
  endtask

  task automatic test_jmp();
    run_instr("jmp", 3'd7, 1'b1, 9'b000001000, 9'b000000000, 9'b000010000, 9'b000011000);
  endtask

  task automatic test_hlt();
    enable = 1'b1;
    opcode = 3'd0;
    do_reset();
    repeat (4) tick();
    n_checks++;
    if (phase !== 3'd4 || outs !== 9'b000000001) begin
      n_fail++;
      $display("FAIL hlt_enter: got outs=%b phase=%0d, want 000000001 phase=4", outs, phase);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 5) begin
        opcode = 3'd2;
        zero   = 1'b1;
        #1;
      end
      n_checks++;
      if (phase !== 3'd4 || outs !== 9'b000000001) begin
        n_fail++;
        $display("FAIL hlt_hold%0d: got outs=%b phase=%0d, want 000000001 phase=4", i, outs, phase);
      end
    end
    do_reset();
    n_checks++;
    if (phase !== 3'd0 || outs !== 9'b100000000) begin
      n_fail++;
      $display("FAIL hlt_clear: got outs=%b phase=%0d, want 100000000 phase=0", outs, phase);
    end
  endtask

  // HLT seen in phase 4 with enable low must not latch.
  task automatic test_hlt_disabled();
    enable = 1'b1;
    opcode = 3'd0;
    do_reset();
    repeat (4) tick();
    enable = 1'b0;
    tick();
    opcode = 3'd5;
    #1;
    n_checks++;
    if (phase !== 3'd4 || outs !== 9'b000001000) begin
      n_fail++;
      $display("FAIL hlt_no_en: got outs=%b phase=%0d, want 000001000 phase=4", outs, phase);
    end
    enable = 1'b1;
    tick();
    n_checks++;
    if (phase !== 3'd5 || outs !== 9'b010000000) begin
      n_fail++;
      $display("FAIL hlt_no_en_adv: got outs=%b phase=%0d, want 010000000 phase=5", outs, phase);
    end
  endtask

  task automatic test_enable_hold();
    enable = 1'b1;
    opcode = 3'd5;
    do_reset();
    repeat (2) tick();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (phase !== 3'd2 || outs !== 9'b111000000) begin
        n_fail++;
        $display("FAIL en_hold%0d: got outs=%b phase=%0d, want 111000000 phase=2", i, outs, phase);
      end
    end
    enable = 1'b1;
    tick();
    n_checks++;
    if (phase !== 3'd3) begin
      n_fail++;
      $display("FAIL en_resume: got phase=%0d, want 3", phase);
    end
  endtask

  initial begin
    rst_   = 1'b0;
    enable = 1'b0;
    opcode = 3'd0;
    zero   = 1'b0;
    #2;
    test_reset();
    test_reset_mid();
    test_lda();
    test_add();
    test_sto();
    test_skz();
    test_jmp();
    test_hlt();
    test_hlt_disabled();
    test_enable_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
